// File: rtl/ex_pkg.sv
// Execute-stage shared definitions: ALU opcodes, divider states, EX register layout.
package ex_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

    // ALU operation codes carried in aluop
    localparam logic [4:0] ALU_ADDU  = 5'd0;
    localparam logic [4:0] ALU_SUBU  = 5'd1;
    localparam logic [4:0] ALU_AND   = 5'd2;
    localparam logic [4:0] ALU_OR    = 5'd3;
    localparam logic [4:0] ALU_XOR   = 5'd4;
    localparam logic [4:0] ALU_NOR   = 5'd5;
    localparam logic [4:0] ALU_SLT   = 5'd6;
    localparam logic [4:0] ALU_SLTU  = 5'd7;
    localparam logic [4:0] ALU_SLL   = 5'd8;
    localparam logic [4:0] ALU_SRL   = 5'd9;
    localparam logic [4:0] ALU_SRA   = 5'd10;
    localparam logic [4:0] ALU_SLLV  = 5'd11;
    localparam logic [4:0] ALU_SRLV  = 5'd12;
    localparam logic [4:0] ALU_SRAV  = 5'd13;
    localparam logic [4:0] ALU_LUI   = 5'd14;
    localparam logic [4:0] ALU_MFHI  = 5'd15;
    localparam logic [4:0] ALU_MFLO  = 5'd16;
    localparam logic [4:0] ALU_MTHI  = 5'd17;
    localparam logic [4:0] ALU_MTLO  = 5'd18;
    localparam logic [4:0] ALU_MULT  = 5'd19;
    localparam logic [4:0] ALU_MULTU = 5'd20;
    localparam logic [4:0] ALU_DIV   = 5'd21;
    localparam logic [4:0] ALU_DIVU  = 5'd22;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [4:0]  sa;
        logic [4:0]  aluop;
        logic [4:0]  writereg;
        logic [1:0]  controls;
    } ex_reg_t;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, 32 RUN cycles.
// Signed divides run on magnitudes; signs are reapplied on the way out.
module div_iter
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    div_state_e  state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] quot_q, quot_d;        // dividend magnitude shifts out, quotient shifts in
    logic [31:0] rem_q, rem_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] dividend_q, dividend_d; // raw dividend, returned as remainder on divide-by-zero
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;

    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic [31:0] a_mag, b_mag;

    // Next-state: latch operands on start, one restoring step per RUN cycle
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;

        a_mag     = (is_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
        b_mag     = (is_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;
        rem_shift = {rem_q, quot_q[31]};
        diff      = rem_shift - {1'b0, divisor_q};

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    state_d    = DIV_RUN;
                    count_d    = 5'd0;
                    quot_d     = a_mag;
                    rem_d      = 32'd0;
                    divisor_d  = b_mag;
                    dividend_d = dividend;
                    neg_quot_d = is_signed & (dividend[31] ^ divisor[31]);
                    neg_rem_d  = is_signed & dividend[31];
                    dz_d       = (divisor == 32'd0);
                end
            end
            DIV_RUN: begin
                // diff[32] set means the trial subtraction borrowed: restore
                if (!diff[32]) begin
                    rem_d  = diff[31:0];
                    quot_d = {quot_q[30:0], 1'b1};
                end else begin
                    rem_d  = rem_shift[31:0];
                    quot_d = {quot_q[30:0], 1'b0};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                if (ack) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // Divider state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= DIV_IDLE;
            count_q    <= 5'd0;
            quot_q     <= 32'd0;
            rem_q      <= 32'd0;
            divisor_q  <= 32'd0;
            dividend_q <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
        end
    end

    assign busy = (state_q != DIV_IDLE);
    assign done = (state_q == DIV_DONE);
    // Divide-by-zero yields all-ones quotient and the untouched dividend
    assign quot = dz_q ? 32'hffffffff : (neg_quot_q ? (32'd0 - quot_q) : quot_q);
    assign rem  = dz_q ? dividend_q   : (neg_rem_q  ? (32'd0 - rem_q)  : rem_q);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: EX pipeline register, ALU, single-cycle multiplier,
// HI/LO write formation and an iterative divider that stalls the pipe.
module ex_stage
    import ex_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] pc_in,
    input  logic [31:0] srca_in,
    input  logic [31:0] srcb_in,
    input  logic [4:0]  sa_in,
    input  logic [4:0]  aluop_in,
    input  logic [4:0]  writereg_in,
    input  logic [1:0]  controls_in,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    output logic [31:0] pc,
    output logic [31:0] aluout,
    output logic [4:0]  writereg,
    output logic [1:0]  controls,
    output logic [63:0] hilo,
    output logic        hilo_write,
    output logic        stall_req
);

    ex_reg_t ex_q, ex_d;

    logic        is_div;
    logic        div_busy, div_done;
    logic [31:0] div_quot, div_rem;
    logic [63:0] prod_s, prod_u;
    logic [31:0] a, b;

    // EX register next value: hold on stall, bubble on flush, else load decode
    always_comb begin
        ex_d = ex_q;
        if (!stall) begin
            if (flush) begin
                ex_d.srca     = 32'd0;
                ex_d.srcb     = 32'd0;
                ex_d.sa       = 5'd0;
                ex_d.aluop    = ALU_ADDU;
                ex_d.writereg = 5'd0;
                ex_d.controls = 2'b00;
            end else begin
                ex_d.pc       = pc_in;
                ex_d.srca     = srca_in;
                ex_d.srcb     = srcb_in;
                ex_d.sa       = sa_in;
                ex_d.aluop    = aluop_in;
                ex_d.writereg = writereg_in;
                ex_d.controls = controls_in;
            end
        end
    end

    // EX pipeline register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ex_q <= '{pc: RESET_PC, default: '0};
        else         ex_q <= ex_d;
    end

    assign a      = ex_q.srca;
    assign b      = ex_q.srcb;
    assign is_div = is_div_op(ex_q.aluop);

    // Divider leaves DONE only when the EX register actually advances
    div_iter u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (is_div & ~div_busy),
        .is_signed (ex_q.aluop == ALU_DIV),
        .dividend  (a),
        .divisor   (b),
        .ack       (~stall),
        .busy      (div_busy),
        .done      (div_done),
        .quot      (div_quot),
        .rem       (div_rem)
    );

    // Sign-extend to 64 bits so one unsigned multiply gives the signed product mod 2^64
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // ALU result and HI/LO write formation
    always_comb begin
        aluout     = 32'd0;
        hilo       = 64'd0;
        hilo_write = 1'b0;
        case (ex_q.aluop)
            ALU_ADDU:  aluout = a + b;
            ALU_SUBU:  aluout = a - b;
            ALU_AND:   aluout = a & b;
            ALU_OR:    aluout = a | b;
            ALU_XOR:   aluout = a ^ b;
            ALU_NOR:   aluout = ~(a | b);
            ALU_SLT:   aluout = {31'd0, ($signed(a) < $signed(b))};
            ALU_SLTU:  aluout = {31'd0, (a < b)};
            ALU_SLL:   aluout = b << ex_q.sa;
            ALU_SRL:   aluout = b >> ex_q.sa;
            ALU_SRA:   aluout = $signed(b) >>> ex_q.sa;
            ALU_SLLV:  aluout = b << a[4:0];
            ALU_SRLV:  aluout = b >> a[4:0];
            ALU_SRAV:  aluout = $signed(b) >>> a[4:0];
            ALU_LUI:   aluout = {b[15:0], 16'd0};
            ALU_MFHI:  aluout = hi_in;
            ALU_MFLO:  aluout = lo_in;
            ALU_MTHI: begin
                hilo       = {a, lo_in};
                hilo_write = 1'b1;
            end
            ALU_MTLO: begin
                hilo       = {hi_in, a};
                hilo_write = 1'b1;
            end
            ALU_MULT: begin
                hilo       = prod_s;
                hilo_write = 1'b1;
            end
            ALU_MULTU: begin
                hilo       = prod_u;
                hilo_write = 1'b1;
            end
            ALU_DIV, ALU_DIVU: begin
                if (div_done) begin
                    hilo       = {div_rem, div_quot};
                    hilo_write = 1'b1;
                end
            end
            default: aluout = 32'd0;
        endcase
    end

    assign stall_req = is_div & ~div_done;
    assign pc        = ex_q.pc;
    assign writereg  = ex_q.writereg;
    assign controls  = ex_q.controls;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, directly upstream of the memory stage. Registers decoded operands from decode, computes the ALU result, forms 64-bit HI/LO values for MULT/MULTU/DIV/DIVU/MTHI/MTLO, and presents pc, aluout, writereg, controls and hilo/hilo_write to the memory stage. Division is iterative (32 cycles), and the block raises a stall request to the hazard unit while a divide runs.

## Interface
- Parameters:
- RESET_PC, 32'hbfc00000, pc value held in the EX register after reset
- Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous and active-low
- stall  in  1  hazard-unit stall; EX register holds when high
- flush  in  1  load a bubble into the EX register (priority over load; ignored while stall=1)
- pc_in  in  32  decode pc
- srca_in, srcb_in  in  32 each  operands (immediate already muxed into srcb_in)
- sa_in  in  5  shift amount
- aluop_in  in  5  operation code (ex_pkg)
- writereg_in  in  5  destination register
- controls_in  in  2  [1]=regwrite, [0]=memtoreg; passed through
- hi_in, lo_in  in  32 each  current (forwarded) HI/LO for MFHI/MFLO
- pc  out  32  EX-register pc
- aluout  out  32  ALU result
- writereg  out  5  destination
- controls  out  2  passed-through controls
- hilo  out  64  {HI,LO} value to write
- hilo_write  out  1  HI/LO write enable
- stall_req  out  1  divide in progress; hazard unit must stall IF/ID/EX and bubble MEM

## Operation
- EX register: {pc, srca, srcb, sa, aluop, writereg, controls}. resetn=0: pc=RESET_PC, all else 0. Else if stall=0: flush ? bubble (aluop=ADDU, operands 0, controls 0, writereg 0, pc unchanged) : load *_in. stall=1: hold.
- Outputs combinational from EX register and divider.
- ALU ops: ADDU, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA (shift by sa), SLLV, SRLV, SRAV (shift by srca[4:0], value srcb), LUI ({srcb[15:0],16'b0}), MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU. ADD/SUB overflow traps not implemented (wrap, same as ADDU/SUBU).
- Width rules: SLT signed 32-bit compare; MULT signed 32x32->64, MULTU unsigned, single-cycle; hilo={hi,lo}.
- MTHI: hilo={srca,lo_in}; MTLO: hilo={hi_in,srca}; hilo_write=1 for MULT/MULTU/MTHI/MTLO; for DIV/DIVU only in divider DONE. hilo_write=0 otherwise; hilo=0 when hilo_write=0.
- Divider FSM: IDLE, RUN, DONE. IDLE and aluop in {DIV,DIVU} -> RUN, latching |operands| (DIV) or raw (DIVU) and sign flags, count=0. RUN: one restoring step per cycle; count=31 -> DONE. DONE -> IDLE when EX register loads (stall=0) or resetn=0.
- stall_req = div op in EX and state != DONE.
- DIV sign fix: quotient negative iff signs differ; remainder takes dividend sign. 0x80000000 / -1 -> quot 0x80000000, rem 0. Divide by zero (both): quot 32'hffffffff, rem = dividend.

## Timing
- Non-divide: zero added latency; outputs valid same cycle EX register updates.
- Divide: EX occupied 34 cycles (1 IDLE, 32 RUN, 1 DONE); stall_req high for first 33; hilo_write=1 in DONE cycle only.
- Reset mid-divide: FSM to IDLE, stall_req=0 immediately (async).
- flush with stall=0 during DONE: bubble loads, FSM -> IDLE. External stall in DONE: hold DONE, hilo_write stays 1.
- Back-to-back divides: second enters EX on DONE-cycle load, FSM passes through IDLE, restarts next cycle.

## Structure
- ex_pkg: aluop localparams, divider state encoding, RESET_PC default.
- Sub-module div_iter: iterative 32-cycle signed/unsigned divider with start/done/busy; ALU and multiplier stay in ex_stage.

## Test plan
- Reset: resetn=0 -> pc=bfc00000, aluout=0, controls=0, hilo_write=0, stall_req=0.
- srca=7, srcb=fffffff9 SLT -> aluout=0; SLTU -> 1; SRA sa=4 on srcb=80000000 -> f8000000.
- MULT ffffffff x 2 -> hilo=ffffffff_fffffffe, hilo_write=1 same cycle; MULTU -> 00000001_fffffffe.
- DIV -7/2 -> stall_req high 33 cycles, then hilo={ffffffff,fffffffd}, hilo_write one cycle.
- DIVU x/0 and DIV 80000000/ffffffff -> quot ffffffff rem x; quot 80000000 rem 0.
- resetn pulsed at RUN cycle 10 -> stall_req drops at once; next DIV completes normally in 34 cycles.
